// File: rtl/pkt_pkg.sv
// Shared definitions for the packet framer and the downstream tracker bench:
// FSM state encoding and the default length-field width.
package pkt_pkg;

   localparam int LEN_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_BODY = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

endpackage

// File: rtl/pkt_framer_if.sv
// Request port and frame-beat outputs of pkt_framer, bundled as one interface.
interface pkt_framer_if
   import pkt_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) ();

   logic             req_valid;
   logic [LEN_W-1:0] req_len;
   logic             req_ready;
   logic             head;
   logic             tail;
   logic             valid;
   logic             busy;
   logic             frame_done;
   logic             err_zero;

   modport master (
      output req_valid, req_len,
      input  req_ready, head, tail, valid, busy, frame_done, err_zero
   );

   modport slave (
      input  req_valid, req_len,
      output req_ready, head, tail, valid, busy, frame_done, err_zero
   );

endinterface

// File: rtl/len_fifo.sv
// Synchronous show-ahead FIFO of frame lengths; rdata is the head entry
// whenever empty is low.
module len_fifo #(
   parameter int LEN_W = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [LEN_W-1:0] wdata,
   input  logic             pop,
   output logic [LEN_W-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   logic [LEN_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         // Simultaneous push and pop leave occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/pkt_framer.sv
// Frame generator: queues length requests and emits each as a contiguous run
// of valid beats with head/tail markers, followed by a GAP-cycle idle gap.
module pkt_framer
   import pkt_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF,
   parameter int DEPTH = 4,
   parameter int GAP   = 1
) (
   input  logic         clock,
   input  logic         reset,
   pkt_framer_if.slave  bus
);

   localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

   localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
   localparam logic [1:0] S_HEAD = 2'(ST_HEAD);
   localparam logic [1:0] S_BODY = 2'(ST_BODY);
   localparam logic [1:0] S_GAP  = 2'(ST_GAP);
   // With no gap configured the tail beat returns straight to IDLE.
   localparam logic [1:0] S_END  = (GAP == 0) ? S_IDLE : S_GAP;

   localparam logic [GW-1:0]    GAP_LD = GW'(GAP);
   localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);

   logic [1:0]       state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt;
   logic [GW-1:0]    gap_cnt;
   logic             head_q;
   logic             tail_q;
   logic             valid_q;
   logic             done_q;
   logic             err_q;

   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic             fifo_push;
   logic [LEN_W-1:0] fifo_len;

   assign bus.req_ready = !fifo_full && !reset;
   assign fifo_push     = bus.req_valid && bus.req_ready;
   assign fifo_pop      = (state == S_IDLE) && !fifo_empty;

   len_fifo #(
      .LEN_W (LEN_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .wdata (bus.req_len),
      .pop   (fifo_pop),
      .rdata (fifo_len),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         len_q   <= '0;
         cnt     <= '0;
         gap_cnt <= '0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (fifo_pop) begin
                  if (fifo_len == '0) begin
                     err_q <= 1'b1;
                  end else begin
                     len_q <= fifo_len;
                     state <= S_HEAD;
                  end
               end
            end
            S_HEAD: begin
               head_q  <= 1'b1;
               valid_q <= 1'b1;
               if (len_q == ONE) begin
                  tail_q  <= 1'b1;
                  done_q  <= 1'b1;
                  gap_cnt <= GAP_LD;
                  state   <= S_END;
               end else begin
                  cnt   <= len_q - ONE;
                  state <= S_BODY;
               end
            end
            S_BODY: begin
               valid_q <= 1'b1;
               if (cnt != '0) cnt <= cnt - ONE;
               if (cnt == ONE) begin
                  tail_q  <= 1'b1;
                  done_q  <= 1'b1;
                  gap_cnt <= GAP_LD;
                  state   <= S_END;
               end
            end
            S_GAP: begin
               if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
               if (gap_cnt <= GW'(1)) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.head       = head_q;
   assign bus.tail       = tail_q;
   assign bus.valid      = valid_q;
   assign bus.frame_done = done_q;
   assign bus.err_zero   = err_q;
   assign bus.busy       = (state != S_IDLE) || valid_q;

endmodule

// File: tb/tb_pkt_framer.sv
// Scoreboard bench for pkt_framer: requested lengths are queued on push and
// matched against observed frames and zero-length error pulses.
module tb_pkt_framer;
   import pkt_pkg::*;

   localparam int LW  = 8;
   localparam int TMO = 3000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   pkt_framer_if #(.LEN_W(LW)) bus ();
   pkt_framer_if #(.LEN_W(LW)) bus0 ();

   pkt_framer #(.LEN_W(LW), .DEPTH(4), .GAP(1)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   pkt_framer #(.LEN_W(LW), .DEPTH(4), .GAP(0)) u_dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   int sb[$];

   bit in_frame    = 0;
   bit prev_tail   = 0;
   bit gap_chk_en  = 0;
   int beats       = 0;
   int low_run     = 0;
   int frames_seen = 0;
   int zeros_seen  = 0;
   int valid_total = 0;
   int tails_seen  = 0;

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clock) begin
      #1;
      if (reset) begin
         in_frame  = 0;
         prev_tail = 0;
         beats     = 0;
      end else begin
         if (prev_tail) check("gap_after_tail", bus.valid, 0);
         prev_tail = 0;
         if (bus.err_zero) begin
            if (sb.size() == 0) check("sb_underflow_zero", sb.size(), 1);
            else check("zero_len", 0, sb.pop_front());
            zeros_seen++;
         end
         if (bus.valid) begin
            valid_total++;
            if (bus.head) begin
               check("head_mid_frame", in_frame, 0);
               if (gap_chk_en) check("b2b_gap", low_run, 2);
               in_frame = 1;
               beats    = 0;
            end else if (!in_frame) begin
               check("orphan_beat", in_frame, 1);
            end
            beats++;
            check("done_eq_tail", bus.frame_done, bus.tail);
            if (bus.tail) begin
               tails_seen++;
               frames_seen++;
               if (sb.size() == 0) check("sb_underflow_frame", sb.size(), 1);
               else check("frame_len", beats, sb.pop_front());
               in_frame  = 0;
               prev_tail = 1;
            end
            low_run = 0;
         end else begin
            check("marker_without_valid", {bus.head, bus.tail, bus.frame_done}, 0);
            check("hole_in_frame", in_frame, 0);
            in_frame = 0;
            low_run++;
         end
      end
   end

   task automatic push(input int len, output bit waited);
      int t;
      t      = 0;
      waited = 0;
      bus.req_valid = 1'b1;
      bus.req_len   = LW'(len);
      while (!bus.req_ready && t < TMO) begin
         waited = 1;
         @(negedge clock);
         t++;
      end
      check("push_accept", int'(t < TMO), 1);
      sb.push_back(len);
      @(negedge clock);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while ((sb.size() != 0 || bus.busy) && t < TMO) begin
         @(posedge clock);
         #1;
         t++;
      end
      check(tag, int'(t < TMO), 1);
      @(negedge clock);
   endtask

   task automatic wait_head(input string tag);
      int t;
      t = 0;
      do begin
         @(posedge clock);
         #1;
         t++;
      end while (!bus.head && t < TMO);
      check(tag, int'(t < TMO), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit w;
      int v0, z0, f0, t0;
      int cyc, tail_t, head2_t, nheads, v;

      bus.req_valid  = 1'b0;
      bus.req_len    = '0;
      bus0.req_valid = 1'b0;
      bus0.req_len   = '0;

      repeat (3) @(negedge clock);
      check("rst_outputs", {bus.head, bus.tail, bus.valid, bus.busy,
                            bus.frame_done, bus.err_zero}, 0);
      check("rst_ready", bus.req_ready, 0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("ready_after_rst", bus.req_ready, 1);
      @(negedge clock);

      // len = 2 with first-request latency
      push(2, w);
      @(posedge clock); #1;
      check("lat_e1_head", bus.head, 0);
      @(posedge clock); #1;
      check("lat_e2_head_valid", {bus.head, bus.valid, bus.tail}, 3'b110);
      @(posedge clock); #1;
      check("len2_tail_beat", {bus.head, bus.valid, bus.tail, bus.frame_done}, 4'b0111);
      @(posedge clock); #1;
      check("len2_gap_low", bus.valid, 0);
      wait_idle("len2_idle");

      // len = 1
      push(1, w);
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("len1_htv", {bus.head, bus.tail, bus.valid}, 3'b111);
      wait_idle("len1_idle");

      // len = 0
      v0 = valid_total;
      z0 = zeros_seen;
      push(0, w);
      wait_idle("len0_idle");
      repeat (3) @(negedge clock);
      check("len0_no_valid", valid_total, v0);
      check("len0_err_pulse", zeros_seen, z0 + 1);

      // FIFO fill while a long frame keeps the FSM busy
      f0 = frames_seen;
      push(20, w);
      wait_head("stall_head");
      @(negedge clock);
      gap_chk_en = 1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) check("full_ready_low", bus.req_ready, 0);
         push(3, w);
         check("push_wait", w, int'(i == 4));
      end
      wait_idle("stall_idle");
      gap_chk_en = 0;
      check("stall_frames", frames_seen - f0, 6);

      // maximum length
      f0 = frames_seen;
      push(255, w);
      wait_idle("max_idle");
      check("max_frames", frames_seen - f0, 1);

      // reset on beat 3 of a len = 8 frame with another request queued
      t0 = tails_seen;
      push(8, w);
      push(2, w);
      wait_head("rst_head");
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("rst_beat3_valid", bus.valid, 1);
      @(negedge clock);
      reset = 1'b1;
      sb.delete();
      @(posedge clock); #1;
      check("rst_mid_outputs", {bus.head, bus.tail, bus.valid, bus.busy,
                                bus.frame_done, bus.err_zero}, 0);
      check("rst_mid_ready", bus.req_ready, 0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      check("ready_after_release", bus.req_ready, 1);
      v0 = valid_total;
      repeat (30) @(posedge clock);
      #1;
      check("no_tail_aborted", tails_seen, t0);
      check("fifo_flushed", valid_total, v0);
      check("idle_after_flush", bus.busy, 0);
      @(negedge clock);

      // GAP = 0 instance: two queued len = 4 frames
      bus0.req_valid = 1'b1;
      bus0.req_len   = LW'(4);
      check("gap0_ready", bus0.req_ready, 1);
      @(negedge clock);
      @(negedge clock);
      bus0.req_valid = 1'b0;
      cyc = 0; tail_t = -1; head2_t = -1; nheads = 0; v = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock); #1;
         cyc++;
         if (bus0.valid) v++;
         if (bus0.head) begin
            if (nheads == 1) head2_t = cyc;
            nheads++;
         end
         if (bus0.tail && tail_t < 0) tail_t = cyc;
      end
      check("gap0_spacing", head2_t - tail_t, 2);
      check("gap0_beats", v, 8);
      check("gap0_heads", nheads, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pkt_framer.md
# pkt_framer

Upstream frame generator for the `fsm` packet tracker. It accepts frame-length requests on a valid/ready port and buffers them in a small FIFO. It emits each frame as a contiguous run of `valid` beats, with `head` on the first beat and `tail` on the last, followed by a programmable idle gap. Its `head`/`tail`/`valid` outputs connect directly to the tracker's inputs of the same names, on the same `clock`/`reset`.

## Interface
Parameters:
- `LEN_W`, 8: width of the length field; maximum frame length is 2^LEN_W−1 beats.
- `DEPTH`, 4: request FIFO entries; must be a power of 2, ≥2.
- `GAP`, 1: idle cycles forced between frames (`valid` low); 0 allows back-to-back frames.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: sole clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_len` in LEN_W: frame length in beats.
- `req_ready` out 1: FIFO can accept.
- `head` out 1: first beat of frame.
- `tail` out 1: last beat of frame.
- `valid` out 1: beat present.
- `busy` out 1: frame in progress or gap running.
- `frame_done` out 1: one-cycle pulse, coincident with the tail beat.
- `err_zero` out 1: one-cycle pulse when a zero-length request is popped.

## Operation
- Accept on a rising edge with `req_valid && req_ready`. `req_ready = !full && !reset`, with no bypass: when full, a request is refused even if a pop happens in the same cycle.
- FIFO is show-ahead. It pops when the FSM is in IDLE and the FIFO is not empty.
- FSM states and transitions:
  - IDLE → HEAD on pop with len ≥ 1.
  - A pop with len = 0 is discarded, stays IDLE and pulses `err_zero` on the next cycle.
  - HEAD, len = 1: single beat with `head = tail = valid = 1`. Then GAP, or IDLE if GAP = 0.
  - HEAD, len ≥ 2: `head = valid = 1`, remaining-beats counter loaded with len−1, → BODY.
  - BODY: `valid = 1`, counter decrements each cycle. `tail` is asserted when counter == 1, then → GAP, or IDLE if GAP = 0.
  - GAP: `valid = 0` for exactly GAP cycles, then → IDLE.
- With GAP = 0 and a non-empty FIFO, the next HEAD follows the previous tail after exactly one IDLE cycle (the pop cycle).
- `head`, `tail` and `valid` are registered. `head`/`tail` never assert without `valid`.
- Counters use unsigned arithmetic. The remaining-beats counter is LEN_W bits and never underflows. The FIFO pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a separate log2(DEPTH)+1-bit count.
- Reset values: `head = tail = valid = busy = frame_done = err_zero = 0`; `req_ready = 0` while reset is high. FSM goes to IDLE, FIFO is emptied and counters are zeroed.

## Timing
- Latency: a request accepted at edge E with the FSM idle and the FIFO empty is popped at E+1; `head` is visible after edge E+2.
- Frame of length L occupies exactly L consecutive `valid` cycles.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- Reset mid-frame: outputs are 0 after the reset edge. No `tail` or `frame_done` is emitted for the aborted frame, and queued requests are lost.
- `req_ready` rises the cycle after the edge at which reset deasserts.

## Structure
- Shared package `pkt_pkg` holds the FSM state enum (IDLE, HEAD, BODY, GAP) and the default `LEN_W` constant, shared with the `fsm` tracker bench.
- One sub-module, `len_fifo`: a synchronous show-ahead FIFO parameterised by `LEN_W` and `DEPTH`, with full/empty flags and its own synchronous reset. The framer FSM and counters live in `pkt_framer`.

## Test plan
- Single request, len = 2, GAP = 1: `head` + `valid` on beat 1, `tail` + `valid` + `frame_done` on beat 2, `valid` low for 1 cycle. This matches the tracker's head-then-tail sequence.
- len = 1: one cycle with `head = tail = valid = 1`. Separately, len = 0: no `valid` at all, with an `err_zero` pulse.
- Push 5 requests (len 3) back-to-back with DEPTH = 4 and a stalled FSM: the 5th is held off by `req_ready = 0` until the first pop. All 5 frames emerge, each with 3 beats.
- GAP = 0, two queued len = 4 requests: `tail` of frame 1, then one IDLE cycle, then `head` of frame 2.
- Max length, len = 255: 255 `valid` beats, `tail` only on the 255th, and the counter does not wrap.
- Assert `reset` on beat 3 of a len = 8 frame: all outputs 0 on the next cycle, no `tail`, FIFO empty, and `req_ready` returns after release.
